sine_dds: RTL and testbench

SINE_DDS -- requirements
Module: sine_dds

---
 rtl/sine_dds.sv | 129 ++++++++++++
 tb/tb_sine_dds.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sine_dds.sv
// Sine DDS: phase accumulator feeding a 3-edge quarter-wave table pipeline, offset-binary output.
// Define SINE_DDS_COS_EN to add the quadrature (cos) output sharing the same table and valid.
module sine_dds #(
   parameter int PHASE_W = 24,
   parameter int ADDR_W  = 8,
   parameter int OUT_W   = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               en,
   input  logic               sync_clr,
   input  logic               cfg_load,
   input  logic [PHASE_W-1:0] fcw,
   input  logic [PHASE_W-1:0] poff,
`ifdef SINE_DDS_COS_EN
   output logic [OUT_W-1:0]   cos,
`endif
   output logic [OUT_W-1:0]   sine,
   output logic               out_valid
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int MAG_W = OUT_W - 1;
   localparam logic [OUT_W-1:0] MID    = {1'b1, {MAG_W{1'b0}}};
   localparam logic [OUT_W-1:0] MID_LO = {1'b0, {MAG_W{1'b1}}};

   // Half-step sample points keep the table symmetric so T[~a] mirrors the second quadrant exactly.
   function automatic logic [MAG_W-1:0] tab_val(input int i);
      real amp;
      real ang;
      amp = real'((1 << MAG_W) - 1);
      ang = 3.14159265358979323846 * (real'(i) + 0.5) / real'(1 << (ADDR_W + 1));
      return MAG_W'($rtoi(amp * $sin(ang) + 0.5));
   endfunction

   logic [MAG_W-1:0] qtab [DEPTH];
   for (genvar g = 0; g < DEPTH; g++) begin : g_tab
      assign qtab[g] = tab_val(g);
   end

   logic [PHASE_W-1:0] acc;
   logic [PHASE_W-1:0] fcw_reg;
   logic [PHASE_W-1:0] poff_reg;
   logic [PHASE_W-1:0] s1_phase;
   logic               s1_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc      <= '0;
         fcw_reg  <= '0;
         poff_reg <= '0;
         s1_phase <= '0;
         s1_valid <= 1'b0;
      end else begin
         if (cfg_load) begin
            fcw_reg  <= fcw;
            poff_reg <= poff;
         end
         if (sync_clr) begin
            acc      <= '0;
            s1_valid <= 1'b0;
         end else begin
            s1_valid <= en;
            if (en) begin
               s1_phase <= acc + poff_reg;
               acc      <= acc + fcw_reg;
            end
         end
      end
   end

   logic [1:0]        quad;
   logic [ADDR_W-1:0] addr;
   assign quad = s1_phase[PHASE_W-1 -: 2];
   assign addr = s1_phase[PHASE_W-3 -: ADDR_W];

   if (PHASE_W > ADDR_W + 2) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^s1_phase[PHASE_W-ADDR_W-3:0];
   end

   logic [MAG_W-1:0] s2_mag;
   logic             s2_neg;
   logic             s2_valid;
`ifdef SINE_DDS_COS_EN
   logic [MAG_W-1:0] s2_cmag;
   logic             s2_cneg;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_mag   <= '0;
         s2_neg   <= 1'b0;
         s2_valid <= 1'b0;
`ifdef SINE_DDS_COS_EN
         s2_cmag  <= '0;
         s2_cneg  <= 1'b0;
`endif
      end else begin
         s2_valid <= s1_valid && !sync_clr;
         s2_mag   <= quad[0] ? qtab[~addr] : qtab[addr];
         s2_neg   <= quad[1];
`ifdef SINE_DDS_COS_EN
         // Quadrant advanced by one: odd/even mirroring swaps, sign follows bit 1 of quad+1.
         s2_cmag  <= quad[0] ? qtab[addr] : qtab[~addr];
         s2_cneg  <= quad[1] ^ quad[0];
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sine      <= MID;
         out_valid <= 1'b0;
`ifdef SINE_DDS_COS_EN
         cos       <= MID;
`endif
      end else if (sync_clr) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            sine <= s2_neg ? (MID_LO - {1'b0, s2_mag}) : (MID + {1'b0, s2_mag});
`ifdef SINE_DDS_COS_EN
            cos  <= s2_cneg ? (MID_LO - {1'b0, s2_cmag}) : (MID + {1'b0, s2_cmag});
`endif
         end
      end
   end
endmodule

// File: tb/tb_sine_dds.sv
// Directed bench for sine_dds: driver queues hand-computed samples with their due cycle,
// a negedge monitor pops and compares whenever out_valid is seen and checks hold between samples.
module tb_sine_dds;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        en;
   logic        sync_clr;
   logic        cfg_load;
   logic [23:0] fcw;
   logic [23:0] poff;
   logic [7:0]  sine;
   logic        out_valid;
`ifdef SINE_DDS_COS_EN
   logic [7:0]  cos;
`endif

   sine_dds dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (en),
      .sync_clr  (sync_clr),
      .cfg_load  (cfg_load),
      .fcw       (fcw),
      .poff      (poff),
`ifdef SINE_DDS_COS_EN
      .cos       (cos),
`endif
      .sine      (sine),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int s;
      int c;
      int due;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   last_sine = 128;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // A sample issued at the edge following this negedge appears after the third edge from now.
   task automatic step(input logic e, input logic c, input logic l,
                       input logic [23:0] f, input logic [23:0] p,
                       input int es, input int ec);
      @(negedge clk);
      en       = e;
      sync_clr = c;
      cfg_load = l;
      fcw      = f;
      poff     = p;
      if (e && !c && es != -2) q.push_back('{es, ec, cyc + 3});
   endtask

   task automatic issue(input int es, input int ec);
      step(1'b1, 1'b0, 1'b0, 24'd0, 24'd0, es, ec);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 24'd0, 24'd0, -2, -2);
   endtask

   function automatic int e031_s(input int i);
      case (i)
         0:       return 128;
         1:       return 129;
         128:     return 218;
         255:     return 255;
         256:     return 255;
         512:     return 127;
         768:     return 0;
         1024:    return 128;
         default: return -1;
      endcase
   endfunction

   function automatic int e031_c(input int i);
      case (i)
         0:       return 255;
         256:     return 127;
         512:     return 0;
         768:     return 128;
         default: return -1;
      endcase
   endfunction

   always @(negedge clk) begin
      if (!reset_n) begin
         last_sine = 128;
      end else if (out_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            mon_e = q.pop_front();
            chk("latency", cyc, mon_e.due);
            if (mon_e.s >= 0) chk("sine", int'(sine), mon_e.s);
`ifdef SINE_DDS_COS_EN
            if (mon_e.c >= 0) chk("cos", int'(cos), mon_e.c);
`endif
         end
         last_sine = int'(sine);
      end else begin
         chk("sine_hold", int'(sine), last_sine);
         if (q.size() > 0 && q[0].due <= cyc) begin
            chk("valid_due", int'(out_valid), 1);
            void'(q.pop_front());
         end
      end
   end

   initial begin
      reset_n  = 1'b0;
      en       = 1'b0;
      sync_clr = 1'b0;
      cfg_load = 1'b0;
      fcw      = '0;
      poff     = '0;
      repeat (2) @(negedge clk);
      chk("reset_sine", int'(sine), 128);
      chk("reset_valid", int'(out_valid), 0);
      reset_n = 1'b1;

      // fcw=0, poff=0: constant mid-scale, first valid two edges after the first issue edge
      step(1'b0, 1'b0, 1'b1, 24'd0, 24'd0, -2, -2);
      for (int i = 0; i < 4; i++) issue(128, 255);
      idle(4);

      // one table index per sample, full wrap after 1024 samples
      step(1'b0, 1'b1, 1'b1, 24'd16384, 24'd0, -2, -2);
      for (int i = 0; i <= 1024; i++) issue(e031_s(i), e031_c(i));
      idle(4);

      // quarter-turn offset; cfg_load coinciding with en must use the old offset
      step(1'b0, 1'b1, 1'b1, 24'd0, 24'd4194304, -2, -2);
      issue(255, 127);
      issue(255, 127);
      step(1'b1, 1'b0, 1'b1, 24'd0, 24'd8388608, 255, 127);
      issue(127, 0);
      idle(4);

      // bubbles: en 1,0,1,1,0
      step(1'b0, 1'b1, 1'b1, 24'd16384, 24'd0, -2, -2);
      issue(128, 255);
      idle(1);
      issue(129, 255);
      issue(130, 255);
      idle(5);

      // sync_clr with en and a new fcw: two in-flight samples dropped, restart at step 2
      step(1'b0, 1'b1, 1'b0, 24'd0, 24'd0, -2, -2);
      issue(128, 255);
      issue(-2, -2);
      issue(-2, -2);
      step(1'b1, 1'b1, 1'b1, 24'd32768, 24'd0, -2, -2);
      issue(128, 255);
      issue(130, 255);
      issue(132, 255);
      idle(5);

      // reset mid-stream with samples in flight
      issue(-2, -2);
      issue(-2, -2);
      @(negedge clk);
      reset_n = 1'b0;
      en      = 1'b1;
      #1;
      chk("rst_mid_sine", int'(sine), 128);
      chk("rst_mid_valid", int'(out_valid), 0);
      q.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      en      = 1'b0;
      idle(4);
      issue(128, 255);
      issue(128, 255);
      idle(5);

      chk("queue_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
